// File: rtl/cpu_tick_generator.sv
// CPU tick generator: divides MAIN_CLOCK into TICK with run/halt/step modes and a sticky finish state.
// Define TICK_CYCLE_COUNTER_EN to build the saturating CYCLE_COUNT counter; otherwise CYCLE_COUNT is tied to 0.
module cpu_tick_generator #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 MAIN_CLOCK,
  input  logic                 RESET,
  input  logic [DIV_WIDTH-1:0] DIVIDE,
  input  logic [1:0]           MODE,
  input  logic                 STEP_REQ,
  input  logic                 PROCESS_FINISHED,
  output logic                 TICK,
  output logic                 TICK_RISE,
  output logic                 RUNNING,
  output logic                 DONE,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT
);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_RUN,
    ST_STEP,
    ST_FINISHED
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_tick;
  logic                 r_rise;
  logic                 r_running;
  logic                 r_done;
  logic                 r_halt_pend;

  logic                 w_toggle;
  logic                 w_rise;

  assign w_toggle = (r_cnt == r_div);

  // TICK goes 0->1 on the coming edge; shared by the strobe and the cycle counter
  assign w_rise = !PROCESS_FINISHED && !r_tick && w_toggle &&
                  (((r_state == ST_RUN) && (MODE == MODE_RUN)) || (r_state == ST_STEP));

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_HALTED;
      r_cnt       <= '0;
      r_div       <= '0;
      r_tick      <= 1'b0;
      r_rise      <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_rise <= w_rise;
      if (PROCESS_FINISHED) begin
        r_state     <= ST_FINISHED;
        r_cnt       <= '0;
        r_tick      <= 1'b0;
        r_running   <= 1'b0;
        r_done      <= 1'b1;
        r_halt_pend <= 1'b0;
      end else begin
        unique case (r_state)
          ST_HALTED: begin
            r_cnt       <= '0;
            r_halt_pend <= 1'b0;
            if (MODE == MODE_RUN) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_div     <= DIVIDE;
            end else if ((MODE == MODE_STEP) && STEP_REQ) begin
              r_state   <= ST_STEP;
              r_running <= 1'b1;
              r_div     <= DIVIDE;
            end
          end
          ST_RUN: begin
            if (!r_tick && (MODE != MODE_RUN)) begin
              r_state   <= ST_HALTED;
              r_running <= 1'b0;
              r_cnt     <= '0;
            end else begin
              // A halt request during the high phase waits for the scheduled falling edge
              if (MODE != MODE_RUN) r_halt_pend <= 1'b1;
              if (w_toggle) begin
                r_cnt  <= '0;
                r_div  <= DIVIDE;
                r_tick <= ~r_tick;
                if (r_tick && (r_halt_pend || (MODE != MODE_RUN))) begin
                  r_state     <= ST_HALTED;
                  r_running   <= 1'b0;
                  r_halt_pend <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
              end
            end
          end
          ST_STEP: begin
            if (w_toggle) begin
              r_cnt  <= '0;
              r_div  <= DIVIDE;
              r_tick <= ~r_tick;
              if (r_tick) begin
                r_state   <= ST_HALTED;
                r_running <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end
          ST_FINISHED: begin
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TICK      = r_tick;
  assign TICK_RISE = r_rise;
  assign RUNNING   = r_running;
  assign DONE      = r_done;

`ifdef TICK_CYCLE_COUNTER_EN
  logic [CNT_WIDTH-1:0] r_count;

  // Saturating count of TICK rising edges
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (w_rise && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign CYCLE_COUNT = r_count;
`else
  assign CYCLE_COUNT = '0;
`endif

endmodule
